// File: rtl/bp_be_pkg.sv
// Shared backend definitions: global widths/constants and the issue-entry struct declaration macro.
// The struct is macro-declared so each user picks its own vaddr/instr/itag widths.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_DECLARE_ISSUE_ENTRY_S(vaddr_width_mp, instr_width_mp, itag_width_mp) \
  typedef struct packed {                                                          \
    logic [itag_width_mp-1:0]  itag;                                               \
    logic [vaddr_width_mp-1:0] pc;                                                 \
    logic [instr_width_mp-1:0] instr;                                              \
  } bp_be_issue_entry_s

package bp_be_pkg;

  localparam int          bp_be_itag_width_gp       = 8;
  localparam logic [31:0] bp_pc_entry_point_gp      = 32'h8000_0124;
  localparam int          bp_be_issue_buffer_els_gp = 4;
  localparam int          bp_instr_step_gp          = 4;

endpackage

`endif

// File: rtl/bp_be_issue_buffer_mem.sv
// Entry storage for the issue buffer: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the occupancy count in the top.
module bp_be_issue_buffer_mem
  import bp_be_pkg::*;
#(
  parameter int els_p   = bp_be_issue_buffer_els_gp,
  parameter int width_p = 79
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_itag_issue_buffer.sv
// Backend entry stage: drops wrong-path fetches against an expected PC, stamps accepted
// instructions with a monotonic itag, and buffers them for in-order valid/yumi issue.
module bp_be_itag_issue_buffer
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = bp_be_issue_buffer_els_gp,
  parameter int itag_width_p  = bp_be_itag_width_gp,
  parameter logic [vaddr_width_p-1:0] pc_entry_point_p = vaddr_width_p'(bp_pc_entry_point_gp)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         fe_v_i,
  input  logic [vaddr_width_p-1:0]     fe_pc_i,
  input  logic [instr_width_p-1:0]     fe_instr_i,
  output logic                         fe_ready_o,
  input  logic                         redirect_v_i,
  input  logic [vaddr_width_p-1:0]     redirect_pc_i,
  output logic                         issue_v_o,
  output logic [vaddr_width_p-1:0]     issue_pc_o,
  output logic [instr_width_p-1:0]     issue_instr_o,
  output logic [itag_width_p-1:0]      issue_itag_o,
  input  logic                         issue_yumi_i,
  output logic [vaddr_width_p-1:0]     expected_pc_o,
  output logic                         dropped_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  `BP_BE_DECLARE_ISSUE_ENTRY_S(vaddr_width_p, instr_width_p, itag_width_p);

  localparam int ptr_w_lp   = $clog2(els_p);
  localparam int cnt_w_lp   = $clog2(els_p+1);
  localparam int entry_w_lp = $bits(bp_be_issue_entry_s);

  localparam logic [ptr_w_lp-1:0]      ptr_one_lp  = ptr_w_lp'(1);
  localparam logic [cnt_w_lp-1:0]      cnt_one_lp  = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0]      cnt_full_lp = cnt_w_lp'(els_p);
  localparam logic [itag_width_p-1:0]  itag_one_lp = itag_width_p'(1);
  localparam logic [vaddr_width_p-1:0] pc_step_lp  = vaddr_width_p'(bp_instr_step_gp);

  logic [ptr_w_lp-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]      count_q, count_d;
  logic [itag_width_p-1:0]  itag_q, itag_d;
  logic [vaddr_width_p-1:0] exp_pc_q, exp_pc_d;
  logic                     dropped_q, dropped_d;

  logic fe_hs, accept, deq;
  bp_be_issue_entry_s w_entry, r_entry;

  assign fe_ready_o = (count_q != cnt_full_lp);
  assign issue_v_o  = (count_q != '0);

  // Redirect squashes any handshake in the same cycle, so it gates every event.
  assign fe_hs  = fe_v_i & fe_ready_o & ~redirect_v_i;
  assign accept = fe_hs & (fe_pc_i == exp_pc_q);
  assign deq    = issue_yumi_i & issue_v_o & ~redirect_v_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    itag_d    = itag_q;
    exp_pc_d  = exp_pc_q;
    dropped_d = fe_hs & ~accept;

    if (redirect_v_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      exp_pc_d = redirect_pc_i;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + ptr_one_lp;
        itag_d   = itag_q + itag_one_lp;
        exp_pc_d = exp_pc_q + pc_step_lp;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + ptr_one_lp;
      end
      if (accept && !deq) begin
        count_d = count_q + cnt_one_lp;
      end else if (deq && !accept) begin
        count_d = count_q - cnt_one_lp;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      itag_q    <= '0;
      exp_pc_q  <= pc_entry_point_p;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      itag_q    <= itag_d;
      exp_pc_q  <= exp_pc_d;
      dropped_q <= dropped_d;
    end
  end

  assign w_entry.itag  = itag_q;
  assign w_entry.pc    = fe_pc_i;
  assign w_entry.instr = fe_instr_i;

  bp_be_issue_buffer_mem #(
    .els_p   (els_p),
    .width_p (entry_w_lp)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (accept),
    .w_addr_i (wr_ptr_q),
    .w_data_i (w_entry),
    .r_addr_i (rd_ptr_q),
    .r_data_o (r_entry)
  );

  assign issue_pc_o    = r_entry.pc;
  assign issue_instr_o = r_entry.instr;
  assign issue_itag_o  = r_entry.itag;
  assign expected_pc_o = exp_pc_q;
  assign dropped_o     = dropped_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_bp_be_itag_issue_buffer.sv
// Directed bench for bp_be_itag_issue_buffer: filtering, ordering, full/redirect, itag wrap, async reset.
module tb_bp_be_itag_issue_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fe_v, fe_ready, redirect_v, issue_v, issue_yumi, dropped;
  logic [38:0] fe_pc, redirect_pc, issue_pc, expected_pc;
  logic [31:0] fe_instr, issue_instr;
  logic [7:0]  issue_itag;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_be_itag_issue_buffer dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .fe_v_i        (fe_v),
    .fe_pc_i       (fe_pc),
    .fe_instr_i    (fe_instr),
    .fe_ready_o    (fe_ready),
    .redirect_v_i  (redirect_v),
    .redirect_pc_i (redirect_pc),
    .issue_v_o     (issue_v),
    .issue_pc_o    (issue_pc),
    .issue_instr_o (issue_instr),
    .issue_itag_o  (issue_itag),
    .issue_yumi_i  (issue_yumi),
    .expected_pc_o (expected_pc),
    .dropped_o     (dropped),
    .count_o       (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [38:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [38:0] pc);
    fe_v = 1'b1; fe_pc = pc; fe_instr = instr_of(pc);
    step();
    fe_v = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [38:0] pc, input logic [7:0] itag);
    check_eq({tag, "_v"}, issue_v, 1);
    check_eq({tag, "_pc"}, issue_pc, pc);
    check_eq({tag, "_itag"}, issue_itag, itag);
    check_eq({tag, "_instr"}, issue_instr, instr_of(pc));
    issue_yumi = 1'b1;
    step();
    issue_yumi = 1'b0;
  endtask

  task automatic redirect(input logic [38:0] pc);
    redirect_v = 1'b1; redirect_pc = pc;
    step();
    redirect_v = 1'b0;
  endtask

  // A yumi is only legal against a valid head.
  always @(negedge clk) begin
    if (reset_n && issue_yumi) check_eq("yumi_while_valid", issue_v, 1);
  end

  initial begin
    logic [38:0] pc_m;
    logic [7:0]  tag_m;

    reset_n = 1'b0; fe_v = 1'b0; fe_pc = '0; fe_instr = '0;
    redirect_v = 1'b0; redirect_pc = '0; issue_yumi = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check_eq("rst_exp_pc", expected_pc, 39'h80000124);
    check_eq("rst_count", count, 0);
    check_eq("rst_issue_v", issue_v, 0);
    check_eq("rst_fe_ready", fe_ready, 1);
    check_eq("rst_dropped", dropped, 0);

    push(39'h80000124);
    push(39'h80000128);
    push(39'h8000012C);
    check_eq("ord_count", count, 3);
    check_eq("ord_exp_pc", expected_pc, 39'h80000130);
    pop_check("ord0", 39'h80000124, 8'd0);
    pop_check("ord1", 39'h80000128, 8'd1);
    pop_check("ord2", 39'h8000012C, 8'd2);
    check_eq("ord_empty", issue_v, 0);

    redirect(39'h80000124);
    push(39'h80000200);
    check_eq("mis_dropped", dropped, 1);
    check_eq("mis_count", count, 0);
    check_eq("mis_issue_v", issue_v, 0);
    check_eq("mis_exp_pc", expected_pc, 39'h80000124);
    step();
    check_eq("mis_dropped_clr", dropped, 0);

    push(39'h80000124);
    push(39'h80000128);
    push(39'h8000012C);
    push(39'h80000130);
    check_eq("full_count", count, 4);
    check_eq("full_ready", fe_ready, 0);
    push(39'h80000134);
    check_eq("full_ign_count", count, 4);
    check_eq("full_ign_exp_pc", expected_pc, 39'h80000134);
    check_eq("full_ign_dropped", dropped, 0);
    pop_check("full0", 39'h80000124, 8'd3);
    check_eq("full_after_pop", count, 3);
    check_eq("both_head_pc", issue_pc, 39'h80000128);
    check_eq("both_head_itag", issue_itag, 8'd4);
    fe_v = 1'b1; fe_pc = 39'h80000134; fe_instr = instr_of(39'h80000134); issue_yumi = 1'b1;
    step();
    fe_v = 1'b0; issue_yumi = 1'b0;
    check_eq("both_count", count, 3);
    check_eq("both_exp_pc", expected_pc, 39'h80000138);
    check_eq("both_new_head", issue_itag, 8'd5);

    fe_v = 1'b1; fe_pc = 39'h80000138; fe_instr = instr_of(39'h80000138); issue_yumi = 1'b1;
    redirect_v = 1'b1; redirect_pc = 39'h80001000;
    step();
    fe_v = 1'b0; issue_yumi = 1'b0; redirect_v = 1'b0;
    check_eq("redir_count", count, 0);
    check_eq("redir_issue_v", issue_v, 0);
    check_eq("redir_exp_pc", expected_pc, 39'h80001000);
    check_eq("redir_ready", fe_ready, 1);
    check_eq("redir_dropped", dropped, 0);
    push(39'h80001000);
    check_eq("redir_push_count", count, 1);
    pop_check("redir_itag", 39'h80001000, 8'd8);

    pc_m = 39'h80001004;
    tag_m = 8'd9;
    for (int i = 0; i < 248; i++) begin
      push(pc_m);
      pop_check("wrap", pc_m, tag_m);
      pc_m = pc_m + 39'd4;
      tag_m = tag_m + 8'd1;
    end
    check_eq("wrap_next_tag", tag_m, 8'd1);
    check_eq("wrap_exp_pc", expected_pc, pc_m);

    push(pc_m);
    push(pc_m + 39'd4);
    check_eq("arst_pre_count", count, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_issue_v", issue_v, 0);
    check_eq("arst_exp_pc", expected_pc, 39'h80000124);
    step();
    reset_n = 1'b1;
    step();
    push(39'h80000124);
    pop_check("arst_itag", 39'h80000124, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
